pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter register and next-PC selection for the single-cycle CPU. Sits directly downstream of the ALU zero detector: consumes its 1-bit `zero` flag together with decoded branch/jump controls, resolves BEQ/BNE, J/JAL and JR, and registers the next instruction address. Adds a one-cycle fetch-start state after reset, a global stall hold, a sticky halt, and two performance counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `stall`  input  1  hold PC and counters' taken count this cycle.
- `halt`  input  1  decoded halt/syscall; enters sticky HALT.
- `zero`  input  1  ALU zero flag (1 = ALU result is all zeros).
- `branch`  input  1  current instruction is BEQ.
- `bne`  input  1  current instruction is BNE.
- `jump`  input  1  current instruction is J/JAL.
- `jr`  input  1  current instruction is JR.
- `imm16`  input  16  branch offset in words, two's complement.
- `target26`  input  26  jump word index.
- `jr_addr`  input  32  register-file value for JR.
- `pc`  output  32  current instruction address (registered).
- `pc_plus4`  output  32  pc + 4 (combinational).
- `branch_taken`  output  1  combinational; redirect away from pc_plus4 this cycle.
- `halted`  output  1  registered; 1 in HALT.
- `cycle_count`  output  32  RUN cycles elapsed.
- `taken_count`  output  32  committed redirects (branches taken + jumps).

## Operation
- States: INIT, RUN, HALT. Encoding at implementer's discretion.
- Reset (async): state=INIT, pc=RESET_PC, halted=0, cycle_count=0, taken_count=0.
- INIT: pc held; next edge goes to RUN unconditionally (stall/halt/control inputs ignored). Gives instruction memory one cycle for the first fetch.
- RUN, per rising edge:
  - `halt`=1: state→HALT, halted→1, pc held, taken_count held; halt wins over stall and any redirect.
  - else `stall`=1: pc and taken_count held.
  - else pc←next_pc; taken_count increments when branch_taken=1.
  - cycle_count increments on every RUN edge, including stalled and halting edges.
- HALT: all registers held until reset; all inputs ignored.
- next_pc priority (highest first):
  1. `jr`: {jr_addr[31:2], 2'b00}.
  2. `jump`: {pc_plus4[31:28], target26, 2'b00}.
  3. (`branch` & `zero`) | (`bne` & ~`zero`): pc_plus4 + (sign_extend(imm16) << 2).
  4. otherwise pc_plus4.
- branch_taken = 1 exactly when case 1, 2 or 3 is selected; forced 0 outside RUN.
- Arithmetic: all sums 32-bit, wrap modulo 2^32, no overflow flag. Sign extension from bit 15.
- `branch` and `bne` both asserted: treated as taken if either condition holds (decoder must not do this; no error flagged).
- Counters wrap from 32'hFFFF_FFFF to 0.

## Timing
- pc latency: next_pc is visible on `pc` one clock after the edge that samples the controls.
- `pc_plus4`, `branch_taken` combinational from `pc` and inputs; `zero` must settle within the cycle (gate-level zero detector is slow; no other logic on that path).
- Reset assertion mid-cycle clears outputs without waiting for clk; first RUN edge is the second rising edge after reset deasserts.
- Stall asserted during INIT has no effect.

## Test plan
- Reset with RESET_PC=32'h0000_0040: pc=0x40, halted=0, counters=0; after 1 edge still 0x40 (INIT); after 2nd edge with no controls pc=0x44.
- BEQ taken at pc=0x100, zero=1, imm16=16'hFFFC -> branch_taken=1, next pc=0xF4, taken_count+1; same with zero=0 -> pc=0x104, taken_count unchanged.
- BNE at pc=0x200, zero=0, imm16=16'h0003 -> pc=0x210; jump with pc=0x1000_0000, target26=26'h0000_010 -> pc=0x1000_0040.
- Priority: jr=1, jump=1, branch=1, zero=1, jr_addr=0x0000_3003 -> pc=0x3000; wrap: pc=0xFFFF_FFFC sequential -> pc=0x0000_0000.
- Stall for 3 cycles at pc=0x80 with branch taken -> pc stays 0x80, taken_count unchanged, cycle_count +3.
- halt and stall together at pc=0x90 -> halted=1, pc=0x90 held for 10 cycles of random inputs; async reset mid-cycle -> pc=RESET_PC immediately, halted=0.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program counter with next-PC selection for BEQ/BNE, J/JAL and JR. Includes a
// one-cycle fetch-start state after reset, a stall hold, a sticky halt and two perf counters.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        zero,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        jr,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        branch_taken,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] taken_count
);

    typedef enum logic [1:0] {INIT, RUN, HALT} state_t;

    state_t      state;
    state_t      state_next;
    logic        run;
    logic        pc_load;
    logic        cond_taken;
    logic [31:0] branch_offset;
    logic [31:0] next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = RUN;
            RUN:     if (halt) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = INIT;
        endcase
    end

    // Halt outranks stall, so a halting edge never loads a new PC.
    always_comb begin
        run     = (state == RUN);
        pc_load = run & ~halt & ~stall;
    end

    // zero feeds only this small term so the slow zero detector stays off longer paths.
    assign cond_taken    = (branch & zero) | (bne & ~zero);
    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_addr & 32'hFFFF_FFFC;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], target26, 2'b00};
        end else if (cond_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    assign branch_taken = run & (jr | jump | cond_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            halted      <= 1'b0;
            cycle_count <= 32'd0;
            taken_count <= 32'd0;
        end else if (run) begin
            cycle_count <= cycle_count + 32'd1;
            if (halt) begin
                halted <= 1'b1;
            end
            if (pc_load) begin
                pc <= next_pc;
                if (branch_taken) begin
                    taken_count <= taken_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus random stimulus,
// every cycle compared against a behavioural PC model.
module tb_pc_next_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk;
    logic        reset;
    logic        stall, halt, zero, branch, bne, jump, jr;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_addr;
    logic [31:0] pc, pc_plus4, cycle_count, taken_count;
    logic        branch_taken, halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model: program counter, mode flags and counters.
    logic [31:0] m_pc, m_cycle, m_taken;
    bit          m_init, m_halted;

    pc_next_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .zero(zero),
        .branch(branch), .bne(bne), .jump(jump), .jr(jr), .imm16(imm16),
        .target26(target26), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
        .branch_taken(branch_taken), .halted(halted),
        .cycle_count(cycle_count), .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_redirect();
        bit active;
        active = !m_init && !m_halted;
        return active && (jr || jump || (branch && zero) || (bne && !zero));
    endfunction

    function automatic logic [31:0] model_next();
        logic signed [31:0] off;
        off = $signed(imm16);
        if (jr) return jr_addr & ~32'd3;
        if (jump) return ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, target26} * 32'd4);
        if ((branch && zero) || (bne && !zero)) return m_pc + 32'd4 + off * 4;
        return m_pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_cycle = 0; m_taken = 0; m_init = 1; m_halted = 0;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic z, input logic b,
                                 input logic n, input logic j, input logic r,
                                 input logic [15:0] imm, input logic [25:0] tgt,
                                 input logic [31:0] ja);
        stall = s; halt = h; zero = z; branch = b; bne = n; jump = j; jr = r;
        imm16 = imm; target26 = tgt; jr_addr = ja;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_pc"}, pc, m_pc);
        checkValue({tag, "_pc_plus4"}, pc_plus4, m_pc + 32'd4);
        checkValue({tag, "_taken"}, {31'd0, branch_taken}, {31'd0, model_redirect()});
        checkValue({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
        checkValue({tag, "_cycles"}, cycle_count, m_cycle);
        checkValue({tag, "_tcount"}, taken_count, m_taken);
    endtask

    // Advances one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        logic [31:0] npc;
        bit          tk;
        npc = model_next();
        tk  = model_redirect();
        if (m_init) begin
            m_init = 0;
        end else if (!m_halted) begin
            m_cycle++;
            if (halt) m_halted = 1;
            else if (!stall) begin
                if (tk) m_taken++;
                m_pc = npc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    endtask

    task automatic jumpTo(input logic [31:0] addr);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 16'd0, 26'd0, addr);
        checkOutput("jr_setup");
        tick();
    endtask

    task automatic randomStep(input bit allow_halt);
        applyStimulus($urandom_range(0, 3) == 0, allow_halt && ($urandom_range(0, 3) == 0),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
                      $urandom_range(0, 7) == 0, 16'($urandom), 26'($urandom), $urandom);
    endtask

    logic [31:0] c0, t0;

    initial begin
        reset = 1'b1;
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_pc", pc, 32'h40);
        checkValue("reset_halted", {31'd0, halted}, 32'd0);
        checkValue("reset_cycles", cycle_count, 32'd0);
        checkValue("reset_tcount", taken_count, 32'd0);
        checkOutput("reset");
        reset = 1'b0;

        idle();
        tick();
        checkValue("init_hold_pc", pc, 32'h40);
        idle();
        checkOutput("first_run");
        tick();
        checkValue("first_run_pc", pc, 32'h44);

        // BEQ taken and not taken
        jumpTo(32'h100);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 16'hFFFC, 26'd0, 32'd0);
        checkValue("beq_taken_flag", {31'd0, branch_taken}, 32'd1);
        checkOutput("beq_taken");
        t0 = m_taken;
        tick();
        checkValue("beq_taken_pc", pc, 32'hF4);
        checkValue("beq_taken_count", taken_count, t0 + 1);
        jumpTo(32'h100);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'hFFFC, 26'd0, 32'd0);
        checkOutput("beq_not");
        t0 = m_taken;
        tick();
        checkValue("beq_not_pc", pc, 32'h104);
        checkValue("beq_not_count", taken_count, t0);

        // BNE and J
        jumpTo(32'h200);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 16'h0003, 26'd0, 32'd0);
        checkOutput("bne");
        tick();
        checkValue("bne_pc", pc, 32'h210);
        jumpTo(32'h1000_0000);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'd0, 26'h0000010, 32'd0);
        checkOutput("jump");
        tick();
        checkValue("jump_pc", pc, 32'h1000_0040);

        // Priority and wrap-around
        applyStimulus(0, 0, 1, 1, 0, 1, 1, 16'h0001, 26'h3FFFFFF, 32'h0000_3003);
        checkOutput("prio");
        tick();
        checkValue("prio_pc", pc, 32'h3000);
        jumpTo(32'hFFFF_FFFC);
        idle();
        checkOutput("wrap");
        tick();
        checkValue("wrap_pc", pc, 32'h0);

        // Stall with a taken branch pending
        jumpTo(32'h80);
        c0 = m_cycle;
        t0 = m_taken;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 1, 0, 0, 0, 16'h0005, 26'd0, 32'd0);
            checkOutput("stall");
            tick();
        end
        checkValue("stall_pc", pc, 32'h80);
        checkValue("stall_tcount", taken_count, t0);
        checkValue("stall_cycles", cycle_count, c0 + 3);

        // Random run phase without halt
        for (int i = 0; i < 300; i++) begin
            randomStep(0);
            checkOutput("rand");
            tick();
        end

        // halt together with stall, then hold under random inputs
        jumpTo(32'h90);
        applyStimulus(1, 1, 1, 1, 0, 1, 1, 16'h1234, 26'h1, 32'h4444);
        checkOutput("halt");
        tick();
        checkValue("halt_flag", {31'd0, halted}, 32'd1);
        checkValue("halt_pc", pc, 32'h90);
        c0 = m_cycle;
        for (int i = 0; i < 10; i++) begin
            randomStep(1);
            checkOutput("halted_hold");
            tick();
        end
        checkValue("halt_hold_pc", pc, 32'h90);
        checkValue("halt_hold_cycles", cycle_count, c0);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checkValue("async_pc", pc, RST_PC);
        checkValue("async_halted", {31'd0, halted}, 32'd0);
        checkOutput("async");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Stall and halt during INIT are ignored
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
        checkOutput("init_stall");
        tick();
        checkValue("init_stall_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            randomStep(0);
            checkOutput("rand2");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
